rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter that shares one resource, such as a downstream datapath port, between four clients.
- The winner's 2-bit index is registered and decoded into a one-hot grant vector.
- A hold counter bounds how long one client can keep the resource while others are waiting.
- Sits between the request sources and the shared resource's select/enable inputs.

---
 rtl/rr_arbiter4.sv | 147 ++++++++++++++
 tb/tb_rr_arbiter4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with bounded hold.
//
// Shares one resource between four clients. The winner's index is
// registered and decoded into a registered one-hot grant. A hold counter
// limits how long one client keeps the resource while another waits;
// without competition a grant is held indefinitely.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         arbiter enable; no grants are issued while low
//   req[3:0]   request vector, bit i = requester i wants the resource
//   grant[3:0] registered one-hot grant, zero when idle
//   grant_idx  binary index of the grantee, meaningful only when busy=1
//   busy       high while a grant is active
//
// Parameters:
//   MAX_HOLD   max consecutive grant cycles while others wait (1..255)
//   CNT_W      hold counter width, 2**CNT_W >= MAX_HOLD
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q,   idx_d;
  logic [1:0]       last_q,  last_d;
  logic [CNT_W-1:0] hold_q,  hold_d;
  logic [3:0]       grant_q, grant_d;

  // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  // Result is {valid, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!res[2] && cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // last_q always equals the current grantee while granted, so the same
  // pointer serves both the idle search and the release/preempt searches.
  logic [2:0] pick_all;
  logic [2:0] pick_oth;
  logic [3:0] req_oth;

  assign req_oth  = req & ~grant_q;
  assign pick_all = rr_pick(req, last_q);
  assign pick_oth = rr_pick(req_oth, last_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    grant_d = grant_q;

    unique case (state_q)
      S_IDLE: begin
        if (en && pick_all[2]) begin
          state_d = S_GRANT;
          idx_d   = pick_all[1:0];
          last_d  = pick_all[1:0];
          hold_d  = '0;
          grant_d = 4'b0001 << pick_all[1:0];
        end
      end

      S_GRANT: begin
        if (!en) begin
          state_d = S_IDLE;
          idx_d   = '0;
          hold_d  = '0;
          grant_d = '0;
        end else if (!req[idx_q]) begin
          // Release: hand over directly with no idle bubble when possible.
          if (pick_all[2]) begin
            idx_d   = pick_all[1:0];
            last_d  = pick_all[1:0];
            hold_d  = '0;
            grant_d = 4'b0001 << pick_all[1:0];
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            hold_d  = '0;
            grant_d = '0;
          end
        end else if (hold_q == HOLD_LIM && pick_oth[2]) begin
          // Preempt: the current holder stays eligible for its next turn.
          idx_d   = pick_oth[1:0];
          last_d  = pick_oth[1:0];
          hold_d  = '0;
          grant_d = 4'b0001 << pick_oth[1:0];
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        hold_d  = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= 2'd3;
      hold_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] g8, g4, g1;
  logic [1:0] i8, i4, i1;
  logic       b8, b4, b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(g8), .grant_idx(i8), .busy(b8)
  );

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(g4), .grant_idx(i4), .busy(b4)
  );

  rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(g1), .grant_idx(i1), .busy(b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (g8 !== 4'b0000 || b8 !== 1'b0 || i8 !== 2'b00) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d grant=%b busy=%b idx=%0d expected 0000/0/0",
                 c, g8, b8, i8);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (g8 !== 4'b0001 || i8 !== 2'd0 || b8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant grant=%b idx=%0d busy=%b expected 0001/0/1",
               g8, i8, b8);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp = 4'b0001 << k;
      tick();
      checks++;
      if (g8 !== exp || b8 !== 1'b1 || i8 !== 2'(k)) begin
        failures++;
        $display("FAIL rotation_first k=%0d grant=%b idx=%0d busy=%b expected %b/%0d/1",
                 k, g8, i8, b8, exp, k);
      end
      req = 4'b1111;
      tick();
      checks++;
      if (g8 !== exp || b8 !== 1'b1) begin
        failures++;
        $display("FAIL rotation_second k=%0d grant=%b busy=%b expected %b/1",
                 k, g8, b8, exp);
      end
      req = 4'b1111 & ~exp;
    end
    tick();
    checks++;
    if (g8 !== 4'b0001 || i8 !== 2'd0 || b8 !== 1'b1) begin
      failures++;
      $display("FAIL rotation_wrap grant=%b idx=%0d busy=%b expected 0001/0/1", g8, i8, b8);
    end
  endtask

  task automatic test_preempt();
    logic [3:0] exp4;
    logic [3:0] exp1;
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp4 = (c <= 4 || c == 9) ? 4'b0001 : 4'b0010;
      exp1 = (c % 2 == 1) ? 4'b0001 : 4'b0010;
      checks++;
      if (g4 !== exp4) begin
        failures++;
        $display("FAIL preempt_hold4 cyc=%0d grant=%b expected %b", c, g4, exp4);
      end
      checks++;
      if (g1 !== exp1) begin
        failures++;
        $display("FAIL preempt_hold1 cyc=%0d grant=%b expected %b", c, g1, exp1);
      end
    end
  endtask

  task automatic test_solo_hold();
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (g8 !== 4'b0100 || i8 !== 2'd2 || b8 !== 1'b1) begin
        failures++;
        $display("FAIL solo_hold8 cyc=%0d grant=%b idx=%0d busy=%b expected 0100/2/1",
                 c, g8, i8, b8);
      end
      checks++;
      if (g1 !== 4'b0100) begin
        failures++;
        $display("FAIL solo_hold1 cyc=%0d grant=%b expected 0100", c, g1);
      end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (g8 !== 4'b0010) begin
      failures++;
      $display("FAIL en_setup grant=%b expected 0010", g8);
    end
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (g8 !== 4'b0000 || b8 !== 1'b0) begin
        failures++;
        $display("FAIL en_low cyc=%0d grant=%b busy=%b expected 0000/0", c, g8, b8);
      end
    end
    en  = 1'b1;
    req = 4'b1010;
    tick();
    checks++;
    if (g8 !== 4'b1000 || i8 !== 2'd3 || b8 !== 1'b1) begin
      failures++;
      $display("FAIL en_resume grant=%b idx=%0d busy=%b expected 1000/3/1", g8, i8, b8);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (g8 !== 4'b1000 || i8 !== 2'd3) begin
      failures++;
      $display("FAIL wrap_setup grant=%b idx=%0d expected 1000/3", g8, i8);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (g8 !== 4'b0001 || i8 !== 2'd0 || b8 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_release grant=%b idx=%0d busy=%b expected 0001/0/1", g8, i8, b8);
    end
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    checks++;
    if (g8 !== 4'b0000 || b8 !== 1'b0 || i8 !== 2'd0) begin
      failures++;
      $display("FAIL midreset grant=%b busy=%b idx=%0d expected 0000/0/0", g8, b8, i8);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (g8 !== 4'b0001 || i8 !== 2'd0) begin
      failures++;
      $display("FAIL midreset_first grant=%b idx=%0d expected 0001/0", g8, i8);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_preempt();
    test_solo_hold();
    test_enable_drop();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
